fsk_tx_sequencer: RTL

Frame sequencer for the FSK transmit path. It replaces the free-running m-sequence as the bit source. It accepts one data byte per frame over a valid/ready handshake. It then emits, one bit per symbol period, a preamble, a sync word, the byte (MSB first) and a stop bit as the tone-select level, and that level drives the mark/space clock chooser ahead of the sine LUT.

---
 rtl/fsk_tx_sequencer_if.sv | 28 ++
 rtl/fsk_tx_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fsk_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// fsk_tx_sequencer_if
//   Byte handshake between a frame requester and the FSK transmit sequencer.
//
//   data_in    : byte to transmit, sampled on the handshake cycle
//   data_valid : requester has a byte
//   data_ready : sequencer accepts a byte this cycle
//
//   master : the requester (drives data_in / data_valid)
//   slave  : the sequencer (drives data_ready)
// ---------------------------------------------------------------------------
interface fsk_tx_sequencer_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/fsk_tx_sequencer.sv
// ---------------------------------------------------------------------------
// fsk_tx_sequencer
//   Frame sequencer feeding the mark/space tone chooser. One byte is accepted
//   per frame. Each frame is sent one bit per symbol period, in this order:
//   an alternating preamble (starting with 1), SYNC_WORD MSB first, the
//   captured byte MSB first, and one stop bit (1). The line idles at mark.
//
//   Ports
//     clk        : system clock
//     rst        : asynchronous reset, active-low
//     dif        : byte handshake (data_in / data_valid / data_ready)
//     tone_sel   : 1 = mark, 0 = space; registered, changes only on bit edges
//     sym_start  : one-cycle pulse on the first cycle of every bit
//     busy       : frame in progress
//     frame_done : one-cycle pulse on the cycle the block returns to IDLE
// ---------------------------------------------------------------------------
module fsk_tx_sequencer #(
    parameter int          BIT_CYCLES    = 81920,
    parameter int          PREAMBLE_BITS = 8,
    parameter logic [7:0]  SYNC_WORD     = 8'hD3
) (
    input  logic                 clk,
    input  logic                 rst,
    fsk_tx_sequencer_if.slave    dif,
    output logic                 tone_sel,
    output logic                 sym_start,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [16:0] CYC_LAST = 17'(BIT_CYCLES - 1);
    localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_BITS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SYNC = 3'd2,
        DATA = 3'd3,
        STOP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] cyc_cnt_q, cyc_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q;

    logic        tone_q, tone_d;
    logic        sym_q, sym_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;

    logic        hs;
    logic        last_cyc;
    logic        bit_last;

    // data_ready is registered from the next state, so it is low while reset
    // is held and rises on the first clock after release.
    assign hs       = dif.data_valid & ready_q;
    assign last_cyc = (cyc_cnt_q == CYC_LAST);

    always_comb begin
        bit_last = 1'b0;
        case (state_q)
            PRE:       bit_last = (bit_cnt_q == PRE_LAST);
            SYNC, DATA: bit_last = (bit_cnt_q == 4'd7);
            STOP:      bit_last = 1'b1;
            default:   bit_last = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (hs)                   state_d = PRE;
            PRE:  if (last_cyc && bit_last) state_d = SYNC;
            SYNC: if (last_cyc && bit_last) state_d = DATA;
            DATA: if (last_cyc && bit_last) state_d = STOP;
            STOP: if (last_cyc)             state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Counters: both held at zero in IDLE, so a handshake always starts the
    // first preamble bit from a clean count.
    always_comb begin
        cyc_cnt_d = 17'd0;
        bit_cnt_d = 4'd0;
        if (state_q != IDLE) begin
            cyc_cnt_d = last_cyc ? 17'd0 : cyc_cnt_q + 17'd1;
            if (!last_cyc) begin
                bit_cnt_d = bit_cnt_q;
            end else if (!bit_last) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_q <= 17'd0;
            bit_cnt_q <= 4'd0;
            shreg_q   <= 8'd0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            if (state_q == IDLE && hs) begin
                shreg_q <= dif.data_in;
            end else if (state_q == DATA && last_cyc) begin
                shreg_q <= {shreg_q[6:0], 1'b0};
            end
        end
    end

    // Output logic: every output is the registered version of a value
    // computed from the upcoming state/bit, so all of them are glitch-free.
    always_comb begin
        tone_d  = tone_q;
        sym_d   = 1'b0;
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == STOP) && last_cyc;
        ready_d = (state_d == IDLE);

        if ((state_q == IDLE) ? hs : (last_cyc && state_d != IDLE)) begin
            sym_d = 1'b1;
            case (state_d)
                PRE:     tone_d = ~bit_cnt_d[0];
                SYNC:    tone_d = SYNC_WORD[3'd7 - bit_cnt_d[2:0]];
                // On entry the MSB is still at [7]; afterwards the shift
                // happens on the same edge, so the next bit is at [6].
                DATA:    tone_d = (state_q == SYNC) ? shreg_q[7] : shreg_q[6];
                default: tone_d = 1'b1;
            endcase
        end

        if (state_d == IDLE) begin
            tone_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_q  <= 1'b1;
            sym_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            tone_q  <= tone_d;
            sym_q   <= sym_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign tone_sel       = tone_q;
    assign sym_start      = sym_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign dif.data_ready = ready_q;

endmodule
